// File: rtl/uv_recon_ctrl.sv
// -----------------------------------------------------------------------------
// uv_recon_ctrl
//   Sequences macroblocks through the chroma reconstruction datapath. It walks
//   a frame in raster order and runs one MB at a time: input handshake, start
//   pulse, wait for done, then output handshake. It also owns the chroma
//   error-diffusion state: the left_derr register and the top_derr line RAM.
//
// Build option:
//   UV_ERR_DIFFUSION_EN - when defined, the controller instantiates the
//   top_derr line RAM and the left_derr register, and runs CLEAR before each
//   frame. When undefined, left_derr and top_derr are tied to 0, CLEAR is
//   skipped and STORE is an empty cycle, so MB timing is unchanged.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   frame_start          1-cycle pulse; latches mb_w/mb_h; ignored while busy
//   mb_w, mb_h           frame size in MBs (mb_w clamped to MAX_MB_W)
//   busy                 high from frame accept until frame_done
//   in_valid / in_ready  input handshake for the current MB
//   recon_start          1-cycle datapath start pulse
//   recon_x, recon_y     current MB column / row
//   recon_done           datapath done pulse, recon_derr valid in same cycle
//   recon_derr           {V e2,e1,e0, U e2,e1,e0}, signed 8b each
//   left_derr            {V l1,l0, U l1,l0}, signed 8b each
//   top_derr_en/addr     datapath read port of the top_derr RAM
//   top_derr             RAM read data, 1-cycle latency
//   out_valid/out_ready  output handshake for the finished MB
//   frame_done           1-cycle pulse after the last MB's out handshake
// -----------------------------------------------------------------------------
module uv_recon_ctrl #(
  parameter int MAX_MB_W = 128,
  parameter int AW       = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic [9:0]  mb_w,
  input  logic [9:0]  mb_h,
  output logic        busy,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        recon_start,
  output logic [9:0]  recon_x,
  output logic [9:0]  recon_y,
  input  logic        recon_done,
  input  logic [47:0] recon_derr,
  output logic [31:0] left_derr,
  input  logic        top_derr_en,
  input  logic [9:0]  top_derr_addr,
  output logic [31:0] top_derr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_IN,
    S_START,
    S_RUN,
    S_STORE,
    S_OUT
  } state_e;

  state_e      state_q;
  logic [9:0]  mb_w_q, mb_h_q, x_q, y_q, clr_q;
  logic        busy_q, in_ready_q, recon_start_q, out_valid_q, frame_done_q;

  logic [9:0]  mb_w_clamp_d;
  logic        last_col_d, last_row_d, clear_last_d;

  assign mb_w_clamp_d = (mb_w > 10'(MAX_MB_W)) ? 10'(MAX_MB_W) : mb_w;
  assign last_col_d   = (x_q == mb_w_q - 10'd1);
  assign last_row_d   = (y_q == mb_h_q - 10'd1);
  assign clear_last_d = (clr_q == mb_w_q - 10'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      mb_w_q        <= '0;
      mb_h_q        <= '0;
      x_q           <= '0;
      y_q           <= '0;
      clr_q         <= '0;
      busy_q        <= 1'b0;
      in_ready_q    <= 1'b0;
      recon_start_q <= 1'b0;
      out_valid_q   <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      recon_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            mb_w_q <= mb_w_clamp_d;
            mb_h_q <= mb_h;
            x_q    <= '0;
            y_q    <= '0;
            clr_q  <= '0;
            if (mb_w == '0 || mb_h == '0) begin
              // Empty frame: acknowledge immediately, never go busy.
              frame_done_q <= 1'b1;
            end else begin
              busy_q <= 1'b1;
`ifdef UV_ERR_DIFFUSION_EN
              state_q <= S_CLEAR;
`else
              state_q    <= S_WAIT_IN;
              in_ready_q <= 1'b1;
`endif
            end
          end
        end
        S_CLEAR: begin
          // One RAM entry zeroed per cycle, mb_w cycles in total.
          clr_q <= clr_q + 10'd1;
          if (clear_last_d) begin
            state_q    <= S_WAIT_IN;
            in_ready_q <= 1'b1;
          end
        end
        S_WAIT_IN: begin
          if (in_valid && in_ready_q) begin
            in_ready_q    <= 1'b0;
            recon_start_q <= 1'b1;
            state_q       <= S_START;
          end
        end
        S_START: state_q <= S_RUN;
        S_RUN: begin
          if (recon_done) state_q <= S_STORE;
        end
        S_STORE: begin
          state_q     <= S_OUT;
          out_valid_q <= 1'b1;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (!last_col_d) begin
              x_q        <= x_q + 10'd1;
              state_q    <= S_WAIT_IN;
              in_ready_q <= 1'b1;
            end else begin
              x_q <= '0;
              y_q <= y_q + 10'd1;
              if (last_row_d) begin
                frame_done_q <= 1'b1;
                busy_q       <= 1'b0;
                state_q      <= S_IDLE;
              end else begin
                state_q    <= S_WAIT_IN;
                in_ready_q <= 1'b1;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign in_ready    = in_ready_q;
  assign recon_start = recon_start_q;
  assign recon_x     = x_q;
  assign recon_y     = y_q;
  assign out_valid   = out_valid_q;
  assign frame_done  = frame_done_q;

`ifdef UV_ERR_DIFFUSION_EN
  logic [47:0]   derr_q;
  logic [31:0]   left_q, top_q;
  logic [31:0]   mem [MAX_MB_W];
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata;
  logic [31:0]   calc_u, calc_v;
  logic [31:0]   store_left_d, store_top_d;

  // One channel {e2,e1,e0} -> {t1,t0,l1,l0}. 3*e2 needs 10 signed bits;
  // >>> floors toward -inf. t1 is taken modulo 256.
  function automatic logic [31:0] diffuse(input logic [23:0] e);
    logic signed [9:0] e2, prod;
    logic [7:0]        l1, t1;
    e2   = {{2{e[23]}}, e[23:16]};
    prod = e2 * 10'sd3;
    l1   = 8'(prod >>> 2);
    t1   = e[23:16] - l1;
    return {t1, e[15:8], l1, e[7:0]};
  endfunction

  assign calc_u       = diffuse(derr_q[23:0]);
  assign calc_v       = diffuse(derr_q[47:24]);
  assign store_left_d = {calc_v[15:0], calc_u[15:0]};
  assign store_top_d  = {calc_v[31:16], calc_u[31:16]};

  // Writes only happen in CLEAR and STORE; the datapath reads only in RUN,
  // so the single write port never collides with a read.
  assign ram_we    = (state_q == S_CLEAR) || (state_q == S_STORE);
  assign ram_waddr = (state_q == S_CLEAR) ? clr_q[AW-1:0] : x_q[AW-1:0];
  assign ram_wdata = (state_q == S_CLEAR) ? '0 : store_top_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      derr_q <= '0;
      left_q <= '0;
    end else begin
      case (state_q)
        S_CLEAR: left_q <= '0;
        S_RUN:   if (recon_done) derr_q <= recon_derr;
        S_STORE: left_q <= store_left_d;
        S_OUT:   if (out_ready && last_col_d) left_q <= '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) top_q <= '0;
    else if (top_derr_en) top_q <= mem[top_derr_addr[AW-1:0]];
  end

  assign left_derr = left_q;
  assign top_derr  = top_q;

  logic unused_addr_hi;
  assign unused_addr_hi = ^top_derr_addr[9:AW];
`else
  assign left_derr = '0;
  assign top_derr  = '0;

  logic unused_diffusion;
  assign unused_diffusion = ^{recon_derr, top_derr_en, top_derr_addr};
`endif

endmodule

// File: tb/tb_uv_recon_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uv_recon_ctrl
//   Self-checking bench for uv_recon_ctrl. Each scenario task drives whole
//   frames and compares outputs against a reference model held in the bench:
//   raster MB order, handshake timing, and error-diffusion values computed
//   with integer arithmetic. Expectations follow UV_ERR_DIFFUSION_EN.
// -----------------------------------------------------------------------------
module tb_uv_recon_ctrl;

`ifdef UV_ERR_DIFFUSION_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        frame_start = 1'b0;
  logic [9:0]  mb_w = '0;
  logic [9:0]  mb_h = '0;
  logic        busy;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        recon_start;
  logic [9:0]  recon_x;
  logic [9:0]  recon_y;
  logic        recon_done = 1'b0;
  logic [47:0] recon_derr = '0;
  logic [31:0] left_derr;
  logic        top_derr_en = 1'b0;
  logic [9:0]  top_derr_addr = '0;
  logic [31:0] top_derr;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        frame_done;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] obs_left_mb0;
  logic [31:0] obs_top_mb1;

  uv_recon_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .mb_w         (mb_w),
    .mb_h         (mb_h),
    .busy         (busy),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .recon_start  (recon_start),
    .recon_x      (recon_x),
    .recon_y      (recon_y),
    .recon_done   (recon_done),
    .recon_derr   (recon_derr),
    .left_derr    (left_derr),
    .top_derr_en  (top_derr_en),
    .top_derr_addr(top_derr_addr),
    .top_derr     (top_derr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // floor(v/4) for any sign
  function automatic int floor_div4(input int v);
    if (v >= 0) return v / 4;
    return -((-v + 3) / 4);
  endfunction

  // {l1,l0} for one channel {e2,e1,e0}
  function automatic logic [15:0] exp_left_ch(input logic [23:0] e);
    int s2, l1;
    s2 = int'($signed(e[23:16]));
    l1 = floor_div4(3 * s2);
    return {l1[7:0], e[7:0]};
  endfunction

  // {t1,t0} for one channel {e2,e1,e0}
  function automatic logic [15:0] exp_top_ch(input logic [23:0] e);
    int s2, l1, t1;
    s2 = int'($signed(e[23:16]));
    l1 = floor_div4(3 * s2);
    t1 = s2 - l1;
    return {t1[7:0], e[15:8]};
  endfunction

  // Runs one whole frame and checks every MB against the model.
  // dly: cycles from recon_start to recon_done (-1 random), bp: out_ready
  // stall cycles (-1 random), spur: inject ignored done/frame_start pulses.
  task automatic run_frame(input int w, input int h, input int dly, input int bp,
                           input bit spur, input bit fixed);
    logic [31:0] ram_m [128];
    logic [31:0] left_m, exp_l, exp_t;
    logic [47:0] d;
    logic [63:0] r;
    int          weff, t, dd, nb, k, mbi;
    bit          last;
    weff = (w > 128) ? 128 : w;
    t = 0;
    while (busy === 1'b1 && t < 2000) begin tick(); t++; end
    frame_start = 1'b1; mb_w = 10'(w); mb_h = 10'(h);
    tick();
    frame_start = 1'b0;
    checks++;
    if (w == 0 || h == 0) begin
      if (frame_done !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL zero_dim_done: frame_done=%b busy=%b, required 1/0", frame_done, busy);
      end
      tick();
      checks++;
      if (frame_done !== 1'b0) begin
        errors++;
        $display("FAIL zero_dim_pulse: frame_done=%b, required 0", frame_done);
      end
      $display("frame %0dx%0d empty", w, h);
      return;
    end
    if (busy !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL frame_accept: busy=%b frame_done=%b, required 1/0", busy, frame_done);
    end
    for (int i = 0; i < weff; i++) ram_m[i] = '0;
    t = 0;
    while (in_ready !== 1'b1 && t < 600) begin tick(); t++; end
    checks++;
    if (t != (EN ? weff : 0)) begin
      errors++;
      $display("FAIL clear_len: in_ready after %0d cycles, required %0d", t, EN ? weff : 0);
    end
    mbi = 0;
    left_m = '0;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < weff; x++) begin
        if (x == 0) left_m = '0;
        k = $urandom_range(0, 2);
        in_valid = 1'b0;
        repeat (k) begin
          tick();
          checks++;
          if (in_ready !== 1'b1 || recon_start !== 1'b0) begin
            errors++;
            $display("FAIL wait_in_hold: in_ready=%b recon_start=%b, required 1/0", in_ready, recon_start);
          end
        end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        exp_l = EN ? left_m : '0;
        checks++;
        if (recon_start !== 1'b1 || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL start_pulse: recon_start=%b in_ready=%b, required 1/0", recon_start, in_ready);
        end
        checks++;
        if (recon_x !== 10'(x) || recon_y !== 10'(y)) begin
          errors++;
          $display("FAIL mb_pos: (%0d,%0d), required (%0d,%0d)", recon_x, recon_y, x, y);
        end
        checks++;
        if (left_derr !== exp_l) begin
          errors++;
          $display("FAIL left_in: left_derr=%h, required %h", left_derr, exp_l);
        end
        if (spur) begin
          r = {$urandom, $urandom};
          recon_done = 1'b1;
          recon_derr = r[47:0];
        end
        tick();
        recon_done = 1'b0;
        checks++;
        if (recon_start !== 1'b0 || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL run_state: recon_start=%b out_valid=%b, required 0/0", recon_start, out_valid);
        end
        top_derr_en = 1'b1;
        top_derr_addr = 10'(x);
        tick();
        top_derr_en = 1'b0;
        exp_t = EN ? ram_m[x] : '0;
        checks++;
        if (top_derr !== exp_t) begin
          errors++;
          $display("FAIL top_read: addr %0d top_derr=%h, required %h", x, top_derr, exp_t);
        end
        if (mbi == 1) obs_top_mb1 = top_derr;
        dd = (dly < 0) ? int'($urandom_range(2, 8)) : dly;
        repeat (dd - 2) tick();
        r = {$urandom, $urandom};
        d = fixed ? 48'h0000_00F9_FD05 : r[47:0];
        recon_done = 1'b1;
        recon_derr = d;
        tick();
        recon_done = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL store_cycle: out_valid=%b, required 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || recon_x !== 10'(x) || recon_y !== 10'(y)) begin
          errors++;
          $display("FAIL out_valid: out_valid=%b at (%0d,%0d), required 1 at (%0d,%0d)",
                   out_valid, recon_x, recon_y, x, y);
        end
        left_m = {exp_left_ch(d[47:24]), exp_left_ch(d[23:0])};
        ram_m[x] = {exp_top_ch(d[47:24]), exp_top_ch(d[23:0])};
        exp_l = EN ? left_m : '0;
        checks++;
        if (left_derr !== exp_l) begin
          errors++;
          $display("FAIL left_store: left_derr=%h, required %h", left_derr, exp_l);
        end
        if (mbi == 0) obs_left_mb0 = left_derr;
        nb = (bp < 0) ? int'($urandom_range(0, 3)) : bp;
        repeat (nb) begin
          if (spur) begin
            r = {$urandom, $urandom};
            recon_done = 1'b1;
            recon_derr = r[47:0];
            frame_start = 1'b1;
            mb_w = 10'd5;
            mb_h = 10'd0;
          end
          tick();
          recon_done = 1'b0;
          frame_start = 1'b0;
          mb_w = 10'(w);
          mb_h = 10'(h);
          checks++;
          if (out_valid !== 1'b1 || in_ready !== 1'b0 || recon_x !== 10'(x) ||
              recon_y !== 10'(y) || frame_done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: ov=%b ir=%b pos=(%0d,%0d) fd=%b busy=%b, required 1/0 (%0d,%0d) 0/1",
                     out_valid, in_ready, recon_x, recon_y, frame_done, busy, x, y);
          end
        end
        $display("MB x=%0d y=%0d derr=%h left=%h top=%h", x, y, d, left_derr, exp_t);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        last = (x == weff - 1) && (y == h - 1);
        checks++;
        if (last) begin
          if (frame_done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL frame_done: fd=%b busy=%b ov=%b, required 1/0/0", frame_done, busy, out_valid);
          end
          tick();
          checks++;
          if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL frame_done_pulse: frame_done=%b, required 0", frame_done);
          end
        end else if (frame_done !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL next_mb: fd=%b ir=%b ov=%b, required 0/1/0", frame_done, in_ready, out_valid);
        end
        mbi++;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, in_ready, recon_start, recon_x, recon_y, left_derr, top_derr, out_valid, frame_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b ir=%b rs=%b x=%0d y=%0d l=%h t=%h ov=%b fd=%b, required all 0",
               busy, in_ready, recon_start, recon_x, recon_y, left_derr, top_derr, out_valid, frame_done);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b ir=%b ov=%b, required 0/0/0", busy, in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    run_frame(2, 1, 10, 0, 1'b0, 1'b0);
  endtask

  task automatic test_diffusion();
    run_frame(1, 2, 5, 0, 1'b0, 1'b1);
    checks++;
    if (obs_left_mb0 !== (EN ? 32'h0000_FA05 : 32'h0)) begin
      errors++;
      $display("FAIL diff_left: left_derr=%h, required %h", obs_left_mb0, EN ? 32'h0000_FA05 : 32'h0);
    end
    checks++;
    if (obs_top_mb1 !== (EN ? 32'h0000_FFFD : 32'h0)) begin
      errors++;
      $display("FAIL diff_top: top_derr=%h, required %h", obs_top_mb1, EN ? 32'h0000_FFFD : 32'h0);
    end
  endtask

  task automatic test_two_rows();
    run_frame(2, 2, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_frame(2, 2, 4, 5, 1'b1, 1'b0);
  endtask

  task automatic test_zero_dims();
    run_frame(0, 3, -1, 0, 1'b0, 1'b0);
    run_frame(4, 0, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_clamp();
    run_frame(200, 1, 2, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int w, h;
    for (int i = 0; i < 4; i++) begin
      w = $urandom_range(1, 5);
      h = $urandom_range(1, 3);
      run_frame(w, h, -1, -1, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int t;
    run_frame(3, 2, -1, 0, 1'b0, 1'b0);
    frame_start = 1'b1; mb_w = 10'd3; mb_h = 10'd2;
    tick();
    frame_start = 1'b0;
    t = 0;
    while (in_ready !== 1'b1 && t < 600) begin tick(); t++; end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, in_ready, recon_start, recon_x, recon_y, left_derr, top_derr, out_valid, frame_done} !== '0) begin
      errors++;
      $display("FAIL reset_async: busy=%b ir=%b rs=%b l=%h t=%h ov=%b fd=%b, required all 0",
               busy, in_ready, recon_start, left_derr, top_derr, out_valid, frame_done);
    end
    tick();
    tick();
    checks++;
    if ({busy, in_ready, recon_start, recon_x, recon_y, left_derr, top_derr, out_valid, frame_done} !== '0) begin
      errors++;
      $display("FAIL reset_hold: busy=%b ir=%b rs=%b l=%h t=%h ov=%b fd=%b, required all 0",
               busy, in_ready, recon_start, left_derr, top_derr, out_valid, frame_done);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle2: busy=%b in_ready=%b, required 0/0", busy, in_ready);
    end
    run_frame(3, 1, -1, 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_diffusion();
    test_two_rows();
    test_backpressure();
    test_zero_dims();
    test_clamp();
    test_random();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
